// File: rtl/fma_pkg.sv
// -----------------------------------------------------------------------------
// fma_pkg
//   Shared types and constants for the fp32 FMA operand sequencer.
//   - seq_state_e : sequencer states (operand loads, settle wait, result hold)
//   - FP32_W, FP32_EXP_MAX : fp32 word width and all-ones exponent
//   - FLG_* : bit positions inside the 4-bit result classification flags
// -----------------------------------------------------------------------------
package fma_pkg;

    localparam int          FP32_W       = 32;
    localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

    localparam int FLG_NAN  = 3;
    localparam int FLG_INF  = 2;
    localparam int FLG_ZERO = 1;
    localparam int FLG_SUB  = 0;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        LOAD_C,
        SETTLE,
        HOLD
    } seq_state_e;

endpackage : fma_pkg

// File: rtl/fp32_classify.sv
// -----------------------------------------------------------------------------
// fp32_classify
//   Combinational classifier of an fp32 value into {nan, inf, zero, subnormal}.
//   Only compiled when FMA_FLAG_EN is defined; the default build has no
//   classifier at all, so the whole module sits inside the guard.
//   Ports:
//     value  in  32  fp32 word to classify
//     flags  out 4   bit FLG_NAN / FLG_INF / FLG_ZERO / FLG_SUB set accordingly
// -----------------------------------------------------------------------------
`ifdef FMA_FLAG_EN
module fp32_classify
    import fma_pkg::*;
(
    input  logic [FP32_W-1:0] value,
    output logic [3:0]        flags
);

    logic [7:0]  exp_f;
    logic [22:0] man_f;

    assign exp_f = value[30:23];
    assign man_f = value[22:0];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        flags = 4'b0000;
        if (exp_f == FP32_EXP_MAX) begin
            flags[FLG_NAN] = (man_f != '0);
            flags[FLG_INF] = (man_f == '0);
        end else if (exp_f == 8'h00) begin
            flags[FLG_ZERO] = (man_f == '0);
            flags[FLG_SUB]  = (man_f != '0);
        end
    end

endmodule : fp32_classify
`endif

// File: rtl/fma_operand_seq.sv
// -----------------------------------------------------------------------------
// fma_operand_seq
//   Issue/capture stage in front of a combinational fp32 FMA (D = A*B + C).
//   Collects A, B, C from a serial valid/ready stream, holds them on fma_a/b/c
//   for SETTLE_CYC cycles, captures fma_d into out_data and offers it on a
//   valid/ready output. One operation in flight at a time.
//   Optional feature macro: FMA_FLAG_EN adds out_flags = {nan, inf, zero, sub}
//   classifying the captured result.
//   Ports:
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     flush               synchronous abort back to LOAD_A
//     in_valid/in_ready   operand stream handshake, in_data carries A, B, C
//     fma_a/fma_b/fma_c   registered operands to the FMA datapath
//     fma_d               FMA datapath result
//     out_valid/out_ready result handshake, out_data carries the captured result
//     busy                high in every state except LOAD_A
//     out_flags           (FMA_FLAG_EN only) classification of out_data
// -----------------------------------------------------------------------------
module fma_operand_seq
    import fma_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP32_W-1:0] in_data,
    output logic [FP32_W-1:0] fma_a,
    output logic [FP32_W-1:0] fma_b,
    output logic [FP32_W-1:0] fma_c,
    input  logic [FP32_W-1:0] fma_d,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP32_W-1:0] out_data,
    output logic              busy
`ifdef FMA_FLAG_EN
    ,
    output logic [3:0]        out_flags
`endif
);

    // Counter starts one below SETTLE_CYC so that capture happens exactly
    // SETTLE_CYC edges after the edge accepting C.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FP32_W-1:0] fma_a_q, fma_a_d;
    logic [FP32_W-1:0] fma_b_q, fma_b_d;
    logic [FP32_W-1:0] fma_c_q, fma_c_d;
    logic              out_valid_q, out_valid_d;
    logic [FP32_W-1:0] out_data_q, out_data_d;
    logic              in_accept;

`ifdef FMA_FLAG_EN
    logic [3:0] flags_q, flags_d;
    logic [3:0] result_flags;

    fp32_classify u_classify (
        .value (fma_d),
        .flags (result_flags)
    );

    assign out_flags = flags_q;
`endif

    // in_ready depends on rst_n too, so nothing is offered while reset is held.
    assign in_ready  = rst_n && (state_q inside {LOAD_A, LOAD_B, LOAD_C});
    assign in_accept = in_valid && in_ready;

    assign fma_a     = fma_a_q;
    assign fma_b     = fma_b_q;
    assign fma_c     = fma_c_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != LOAD_A);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fma_a_d     = fma_a_q;
        fma_b_d     = fma_b_q;
        fma_c_d     = fma_c_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef FMA_FLAG_EN
        flags_d     = flags_q;
`endif
        if (flush) begin
            // Flush outranks any accept or handshake in the same cycle;
            // operands and last result are deliberately left in place.
            state_d     = LOAD_A;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                LOAD_A: if (in_accept) begin
                    fma_a_d = in_data;
                    state_d = LOAD_B;
                end
                LOAD_B: if (in_accept) begin
                    fma_b_d = in_data;
                    state_d = LOAD_C;
                end
                LOAD_C: if (in_accept) begin
                    fma_c_d = in_data;
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        out_data_d  = fma_d;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
`ifdef FMA_FLAG_EN
                        flags_d     = result_flags;
`endif
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                HOLD: if (out_ready) begin
                    // in_ready is low here, so no operand slips in on this edge.
                    out_valid_d = 1'b0;
                    state_d     = LOAD_A;
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            fma_a_q     <= '0;
            fma_b_q     <= '0;
            fma_c_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef FMA_FLAG_EN
            flags_q     <= 4'b0000;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fma_a_q     <= fma_a_d;
            fma_b_q     <= fma_b_d;
            fma_c_q     <= fma_c_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef FMA_FLAG_EN
            flags_q     <= flags_d;
`endif
        end
    end

endmodule : fma_operand_seq

// File: tb/tb_fma_operand_seq.sv
// -----------------------------------------------------------------------------
// tb_fma_operand_seq
//   Directed bench for fma_operand_seq with a behavioural fp32 FMA attached to
//   fma_a/b/c -> fma_d. Table of operations with hand-computed results, then
//   hand-written sequences for back-pressure, gapped input, flush and reset.
// -----------------------------------------------------------------------------
module tb_fma_operand_seq;
    import fma_pkg::*;

    localparam int SETTLE_CYC = 2;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic        in_ready, out_valid, busy;
    logic [31:0] in_data, fma_a, fma_b, fma_c, fma_d, out_data;
`ifdef FMA_FLAG_EN
    logic [3:0]  out_flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // fp32 <-> real conversion good enough for normals, zeros, inf and NaN.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h00)      d = {f[31], 63'b0};
        else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'b0};
        else                        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        if (d[62:52] == 11'h000) return {d[63], 31'b0};
        if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:29]};
        e = int'(d[62:52]) - 896;
        if (e >= 255) return {d[63], 8'hFF, 23'b0};
        if (e <= 0)   return {d[63], 31'b0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fma_model(input logic [31:0] a, b, c);
        return r2f(f2r(a) * f2r(b) + f2r(c));
    endfunction

    assign fma_d = fma_model(fma_a, fma_b, fma_c);

    fma_operand_seq #(.SETTLE_CYC(SETTLE_CYC), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .fma_a     (fma_a),
        .fma_b     (fma_b),
        .fma_c     (fma_c),
        .fma_d     (fma_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef FMA_FLAG_EN
        ,
        .out_flags (out_flags)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one word from a falling edge; returns 1 ns after the accepting edge.
    task automatic send_word(input logic [31:0] w);
        bit done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1;
        in_valid = 1'b0;
        check("accept_timeout", {31'b0, done}, 32'd1);
    endtask

    task automatic send_op(input logic [31:0] a, b, c);
        send_word(a);
        send_word(b);
        send_word(c);
    endtask

    // Counts edges from the C-accept edge until out_valid is seen.
    task automatic wait_valid(input string name, input int exp_lat);
        int lat  = 0;
        bit seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check({name, "_latency"}, lat, exp_lat);
    endtask

    task automatic consume(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
        check({name, "_idle"},       {31'b0, busy},      32'd0);
    endtask

    typedef struct {
        logic [31:0] a, b, c, d;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40400000, 4'b0000}; // 1*2+1 = 3
        vecs[1] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h40E00000, 4'b0000}; // 2*3+1 = 7
        vecs[2] = '{32'h3F800000, 32'h3F800000, 32'h00000000, 32'h3F800000, 4'b0000}; // 1*1+0 = 1
        vecs[3] = '{32'hC0000000, 32'h40000000, 32'h3F800000, 32'hC0400000, 4'b0000}; // -2*2+1 = -3
        vecs[4] = '{32'h00000000, 32'h40000000, 32'h00000000, 32'h00000000, 4'b0010}; // 0*2+0 = 0
        vecs[5] = '{32'h40800000, 32'h3E800000, 32'hBF800000, 32'h00000000, 4'b0010}; // 4*0.25-1 = 0

        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #1 rst_n = 1'b0;
        #11;
        check("rst_in_ready",  {31'b0, in_ready},  32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_out_data",  out_data, 32'h0);
        check("rst_fma_a",     fma_a, 32'h0);
        check("rst_fma_b",     fma_b, 32'h0);
        check("rst_fma_c",     fma_c, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Table of complete operations.
        for (int v = 0; v < 6; v++) begin
            send_op(vecs[v].a, vecs[v].b, vecs[v].c);
            check($sformatf("vec%0d_busy_settle", v), {31'b0, busy}, 32'd1);
            wait_valid($sformatf("vec%0d", v), SETTLE_CYC);
            check($sformatf("vec%0d_data", v), out_data, vecs[v].d);
            check($sformatf("vec%0d_fma_c", v), fma_c, vecs[v].c);
`ifdef FMA_FLAG_EN
            check($sformatf("vec%0d_flags", v), {28'b0, out_flags}, {28'b0, vecs[v].flags});
`endif
            consume($sformatf("vec%0d", v));
        end

        // Back-pressure: result, ready low for 10 cycles, operand offered throughout.
        begin
            int bad = 0;
            send_op(32'h3F800000, 32'h40000000, 32'h3F800000);
            wait_valid("bp", SETTLE_CYC);
            in_valid = 1'b1;
            in_data  = 32'hDEADBEEF;
            repeat (10) begin
                @(negedge clk);
                if (!out_valid || out_data !== 32'h40400000 || in_ready ||
                    fma_a !== 32'h3F800000 || fma_b !== 32'h40000000 || fma_c !== 32'h3F800000)
                    bad++;
            end
            check("bp_stable_cycles_bad", bad, 0);
            consume("bp");
            in_valid = 1'b0;
            check("bp_no_accept_on_handshake", fma_a, 32'h3F800000);
        end

        // Gapped input stream.
        begin
            logic        pat[6]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            logic [31:0] words[6] = '{32'h3F800000, 32'h11111111, 32'h22222222,
                                      32'h40000000, 32'h33333333, 32'h3F800000};
            // Reload different values first so the gapped op must really overwrite them.
            send_op(32'h40000000, 32'h40400000, 32'h40800000);
            wait_valid("gap_pre", SETTLE_CYC);
            consume("gap_pre");
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                in_valid = pat[i];
                in_data  = words[i];
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            check("gap_fma_a", fma_a, 32'h3F800000);
            check("gap_fma_b", fma_b, 32'h40000000);
            check("gap_fma_c", fma_c, 32'h3F800000);
            wait_valid("gap", SETTLE_CYC);
            check("gap_data", out_data, 32'h40400000);
            consume("gap");
        end

        // Flush in LOAD_C with a C word offered.
        send_word(32'h40000000);
        send_word(32'h40400000);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hC1C1C1C1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flc_fma_c_kept", fma_c, 32'h3F800000);
        check("flc_busy",       {31'b0, busy}, 32'd0);
        check("flc_fma_a_kept", fma_a, 32'h40000000);
        send_op(32'h40000000, 32'h40400000, 32'h3F800000);
        wait_valid("flc_fresh", SETTLE_CYC);
        check("flc_fresh_data", out_data, 32'h40E00000);
        consume("flc_fresh");

        // Flush in HOLD together with out_ready.
        begin
            int extra = 0;
            send_op(32'h3F800000, 32'h40000000, 32'h3F800000);
            wait_valid("flh", SETTLE_CYC);
            @(negedge clk);
            flush     = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
            check("flh_valid", {31'b0, out_valid}, 32'd0);
            check("flh_busy",  {31'b0, busy},      32'd0);
            check("flh_data_kept", out_data, 32'h40400000);
            repeat (8) begin
                @(negedge clk);
                if (out_valid) extra++;
            end
            out_ready = 1'b0;
            check("flh_no_second_result", extra, 0);
        end

        // Reset pulse during SETTLE, then inf*0+0.
        begin
            int extra = 0;
            send_op(32'h3F800000, 32'h40000000, 32'h3F800000);
            #3 rst_n = 1'b0;
            #1;
            check("rstp_fma_a", fma_a, 32'h0);
            check("rstp_fma_b", fma_b, 32'h0);
            check("rstp_fma_c", fma_c, 32'h0);
            check("rstp_out_data",  out_data, 32'h0);
            check("rstp_out_valid", {31'b0, out_valid}, 32'd0);
            check("rstp_in_ready",  {31'b0, in_ready},  32'd0);
            check("rstp_busy",      {31'b0, busy},      32'd0);
`ifdef FMA_FLAG_EN
            check("rstp_flags", {28'b0, out_flags}, 32'd0);
`endif
            @(negedge clk);
            rst_n = 1'b1;
            repeat (5) begin
                @(negedge clk);
                if (out_valid) extra++;
            end
            check("rstp_no_result", extra, 0);
            send_op(32'h7F800000, 32'h00000000, 32'h00000000);
            wait_valid("nan", SETTLE_CYC);
            check("nan_exp", {24'b0, out_data[30:23]}, 32'h000000FF);
            check("nan_mant_nonzero", {31'b0, (out_data[22:0] != 23'b0)}, 32'd1);
`ifdef FMA_FLAG_EN
            check("nan_flags", {28'b0, out_flags}, 32'h8);
`endif
            consume("nan");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fma_operand_seq
